// File: rtl/fetch_pkg.sv
// Shared definitions for the RiSC-16 fetch sequencer: default widths,
// reset fetch address and the sequencer state encoding.
package fetch_pkg;

    localparam int ADDR_W_DEF   = 6;
    localparam int WAIT_W_DEF   = 2;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } state_e;

endpackage

// File: rtl/wait_counter.sv
// Memory wait-state counter. On load it captures the requested wait count
// and restarts from zero; while enabled it counts up and stops at the
// latched value. done is decoded from registers only.
module wait_counter
    import fetch_pkg::*;
#(
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [WAIT_W-1:0] wait_in,
    output logic              done
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;
    logic [WAIT_W-1:0] wlat_q;
    logic [WAIT_W-1:0] wlat_d;

    assign done = (cnt_q == wlat_q);

    // Next count: load restarts a fetch, otherwise count up until done.
    always_comb begin
        cnt_d  = cnt_q;
        wlat_d = wlat_q;
        if (load) begin
            wlat_d = wait_in;
            cnt_d  = '0;
        end else if (en && !done) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Counter and latched wait-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wlat_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wlat_q <= wlat_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, holds each fetch for a
// programmable number of wait states, presents the word to decode and
// handles redirects and halt/restart.
//
// Handshake: fetch_valid is high for as long as a word is presented and
// fetch_pc/imem_addr stay constant meanwhile; the word is issued on a rising
// edge where fetch_valid and issue_ready are both high. fetch_valid never
// depends combinationally on issue_ready.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clk0,
    input  logic              reset,
    input  logic [WAIT_W-1:0] wait_cycle,
    input  logic              issue_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              halted,
    output logic [1:0]        state_dbg
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              wc_load;
    logic              wc_en;
    logic              wc_done;

    wait_counter #(
        .WAIT_W (WAIT_W)
    ) u_wait_counter (
        .clk     (clk0),
        .rst_n   (reset),
        .load    (wc_load),
        .en      (wc_en),
        .wait_in (wait_cycle),
        .done    (wc_done)
    );

    // Next state and PC. Redirect wins over everything outside IDLE; every
    // transition into FETCH (including a redirect while already fetching)
    // reloads the wait counter so the new fetch gets a full wait period.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wc_load = 1'b0;
        wc_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                wc_load = 1'b1;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    state_d = FETCH;
                    wc_load = 1'b1;
                end else if (wc_done) begin
                    state_d = VALID;
                end else begin
                    wc_en = 1'b1;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    state_d = FETCH;
                    wc_load = 1'b1;
                end else if (issue_ready) begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                        wc_load = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    state_d = FETCH;
                    wc_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs come straight from registers or a decode of the state.
    assign imem_addr   = pc_q;
    assign fetch_pc    = pc_q;
    assign imem_en     = (state_q == FETCH);
    assign fetch_valid = (state_q == VALID);
    assign halted      = (state_q == HALTED);
    assign state_dbg   = state_q;

endmodule
